alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator side of the integer ALU interface. It accepts operation requests on a valid/ready handshake and drives registered operands and a 4-bit control code to the combinational ALU.
- After a fixed settle time it captures the ALU result and zero flag, then returns them on a valid/ready response handshake.
- Sits between the execute-stage sequencer (or a test/debug master) and the ALU. One operation is in flight at a time.

Parameters:
- SETTLE_CYCLES, 1, clock edges between driving the ALU inputs and sampling its outputs; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB/compare
- req_a  in  32  operand A
- req_b  in  32  operand B
- alu_a  out  32  registered operand A to the ALU
- alu_b  out  32  registered operand B to the ALU
- alu_ctrl  out  4  registered control code to the ALU
- alu_result  in  32  ALU result (combinational)
- alu_zero  in  1  ALU zero flag (combinational)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  32  captured result
- rsp_zero  out  1  captured zero flag
- rsp_illegal  out  1  request op was not one of the four legal codes
- busy  out  1  high in any state except IDLE
- op_count  out  CNT_W  number of responses handed off

Behaviour:
- Reset (asynchronous, active-high):
  - state is IDLE.
  - alu_a, alu_b, alu_ctrl, rsp_result and op_count are all 0.
  - rsp_zero, rsp_illegal, rsp_valid and busy are 0; req_ready is 1.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_a/req_b/req_op into alu_a/alu_b/alu_ctrl, load settle counter with SETTLE_CYCLES-1, go to WAIT.
  - WAIT: req_ready=0. alu_* outputs are held stable. Counter decrements each edge. At the edge where the counter is 0:
    - capture alu_result into rsp_result and alu_zero into rsp_zero;
    - set rsp_illegal = (alu_ctrl not in {0000,0001,0010,0110});
    - go to RESP.
  - RESP: rsp_valid=1, req_ready=0. Response fields are stable until handshake. On rsp_ready, go to IDLE and increment op_count.
- Latency: request accepted at edge N → rsp_valid high after edge N+SETTLE_CYCLES. With SETTLE_CYCLES=1, the response appears in the cycle after acceptance.
- Throughput: the earliest next acceptance is the edge after the response handshake. req_ready is never high in the same cycle as rsp_valid.
- Illegal op:
  - alu_ctrl is still driven unchanged.
  - rsp_result and rsp_zero take whatever the ALU returns (expected result 0, zero 0).
  - rsp_illegal=1. The operation still completes and still counts.
- alu_* outputs keep their last values in IDLE and RESP; they are not cleared after an operation.
- op_count wraps modulo 2^CNT_W without saturation.
- rsp_ready asserted outside RESP is ignored. req_valid outside IDLE is ignored, and the requester holds it.
- Reset mid-operation, in WAIT or RESP:
  - immediate return to IDLE; the pending response is discarded and not counted;
  - all outputs take their reset values.
- SETTLE_CYCLES outside 1..15 is an elaboration error (static assertion).

Test Plan:
- Reset then ADD: req_op=0010, A=0x0000_0005, B=0x0000_0003 → alu_ctrl=0010 one edge after acceptance; rsp_result=0x8, rsp_zero=0, rsp_illegal=0; op_count=1 after handshake.
- SUB equal: op=0110, A=B=0x1234_5678 → rsp_result=0, rsp_zero=1. SUB with A=1, B=2 → rsp_result=0xFFFF_FFFF, rsp_zero=0.
- Backpressure: AND, A=0xF0F0_F0F0, B=0xFF00_FF00, rsp_ready low for 5 cycles → rsp_result=0xF000_F000 held stable, req_ready=0 throughout; a second req_valid is not accepted until the cycle after the handshake.
- Illegal op=1111, A=7, B=9 → rsp_result=0, rsp_zero=0, rsp_illegal=1, op_count increments.
- SETTLE_CYCLES=4: OR, A=0x1, B=0x2 → alu_* stable for 4 edges; rsp_valid rises exactly 4 edges after acceptance; rsp_result=0x3.
- Reset asserted in WAIT, then in RESP → rsp_valid=0, busy=0, req_ready=1 and op_count=0 immediately (before the next clock edge). With CNT_W=2, five completed ops → op_count=1 (wrap).

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational integer ALU: accepts one request, drives registered
// operands, waits a fixed settle time, then hands the captured result back on a response handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a request; alu_* hold the previous operation
// ST_WAIT | operands stable at the ALU, settle counter running down to 0
// ST_RESP | captured result presented, waiting for rsp_ready
module alu_issue_ctrl #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [31:0]      alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_zero,
   output logic             rsp_illegal,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
         $error("alu_issue_ctrl: SETTLE_CYCLES must be within 1..15");
      end
   endgenerate

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] settle_cnt;
   logic       accept;
   logic       capture;
   logic       handoff;
   logic       illegal_op;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      handoff   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (settle_cnt == 4'd0) begin
               capture   = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               handoff   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode straight from the state register so a reset shows up without a clock edge.
   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

   always_comb begin
      illegal_op = 1'b1;
      case (alu_ctrl)
         4'b0000, 4'b0001, 4'b0010, 4'b0110: illegal_op = 1'b0;
         default:                            illegal_op = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         settle_cnt  <= 4'd0;
         alu_a       <= 32'd0;
         alu_b       <= 32'd0;
         alu_ctrl    <= 4'd0;
         rsp_result  <= 32'd0;
         rsp_zero    <= 1'b0;
         rsp_illegal <= 1'b0;
         op_count    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_ctrl   <= req_op;
            settle_cnt <= SETTLE_LOAD;
         end else if (state == ST_WAIT && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
         // Illegal codes still sample the ALU; only the flag distinguishes them.
         if (capture) begin
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_illegal <= illegal_op;
         end
         if (handoff) begin
            op_count <= op_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: unit 0 uses SETTLE_CYCLES=1/CNT_W=16, unit 1 uses SETTLE_CYCLES=4/CNT_W=2.
// Each unit sees its own ALU model; expectations come from a reference computed on the request.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        reset       [2];
   logic        req_valid   [2];
   logic        req_ready   [2];
   logic [3:0]  req_op      [2];
   logic [31:0] req_a       [2];
   logic [31:0] req_b       [2];
   logic [31:0] alu_a       [2];
   logic [31:0] alu_b       [2];
   logic [3:0]  alu_ctrl    [2];
   logic [31:0] alu_result  [2];
   logic        alu_zero    [2];
   logic        rsp_valid   [2];
   logic        rsp_ready   [2];
   logic [31:0] rsp_result  [2];
   logic        rsp_zero    [2];
   logic        rsp_illegal [2];
   logic        busy        [2];
   logic [15:0] op_count0;
   logic [1:0]  op_count1;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          settle [2] = '{1, 4};
   int          exp_cnt [2];
   logic [31:0] exp_res [2];
   logic        exp_zero [2];
   logic        exp_ill [2];
   logic [31:0] exp_a [2];
   logic [31:0] exp_b [2];
   logic [3:0]  exp_op [2];

   alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_op(req_op[0]), .req_a(req_a[0]), .req_b(req_b[0]),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_ctrl(alu_ctrl[0]),
      .alu_result(alu_result[0]), .alu_zero(alu_zero[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
      .rsp_zero(rsp_zero[0]), .rsp_illegal(rsp_illegal[0]), .busy(busy[0]), .op_count(op_count0));

   alu_issue_ctrl #(.SETTLE_CYCLES(4), .CNT_W(2)) dut1 (
      .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_op(req_op[1]), .req_a(req_a[1]), .req_b(req_b[1]),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_ctrl(alu_ctrl[1]),
      .alu_result(alu_result[1]), .alu_zero(alu_zero[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
      .rsp_zero(rsp_zero[1]), .rsp_illegal(rsp_illegal[1]), .busy(busy[1]), .op_count(op_count1));

   for (genvar g = 0; g < 2; g++) begin : g_alu
      always_comb begin
         alu_result[g] = 32'd0;
         alu_zero[g]   = 1'b0;
         case (alu_ctrl[g])
            4'b0000: alu_result[g] = alu_a[g] & alu_b[g];
            4'b0001: alu_result[g] = alu_a[g] | alu_b[g];
            4'b0010: alu_result[g] = alu_a[g] + alu_b[g];
            4'b0110: alu_result[g] = alu_a[g] - alu_b[g];
            default: alu_result[g] = 32'd0;
         endcase
         if (alu_ctrl[g] inside {4'b0000, 4'b0001, 4'b0010, 4'b0110})
            alu_zero[g] = (alu_result[g] == 32'd0);
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] cnt_of(input int u);
      return (u == 0) ? op_count0 : {14'd0, op_count1};
   endfunction

   function automatic int cnt_mod(input int u);
      return (u == 0) ? 65536 : 4;
   endfunction

   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic z, output logic ill);
      ill = 1'b0;
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: r = a + b;
         4'd6: r = a - b;
         default: begin r = 32'd0; ill = 1'b1; end
      endcase
      z = !ill && (r == 32'd0);
   endfunction

   // Present a request from an idle unit and follow it until rsp_valid, checking latency and fields.
   task automatic issue(input int u, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int lat;
      exp_op[u] = op; exp_a[u] = a; exp_b[u] = b;
      model(op, a, b, exp_res[u], exp_zero[u], exp_ill[u]);
      n_cmp++;
      if (req_ready[u] !== 1'b1) begin
         n_bad++; $display("FAIL req_ready_idle u%0d: got %b want 1", u, req_ready[u]);
      end
      req_valid[u] = 1'b1; req_op[u] = op; req_a[u] = a; req_b[u] = b;
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
      req_a[u] = $urandom; req_b[u] = $urandom; req_op[u] = 4'($urandom);
      n_cmp++;
      if (alu_a[u] !== a || alu_b[u] !== b || alu_ctrl[u] !== op) begin
         n_bad++; $display("FAIL alu_drive u%0d: got %h/%h/%h want %h/%h/%h",
                           u, alu_a[u], alu_b[u], alu_ctrl[u], a, b, op);
      end
      lat = 0;
      while (rsp_valid[u] !== 1'b1 && lat < 40) begin
         n_cmp++;
         if (req_ready[u] !== 1'b0 || busy[u] !== 1'b1 || alu_a[u] !== a || alu_b[u] !== b
             || alu_ctrl[u] !== op) begin
            n_bad++; $display("FAIL wait_hold u%0d: ready %b busy %b alu %h/%h/%h", u,
                              req_ready[u], busy[u], alu_a[u], alu_b[u], alu_ctrl[u]);
         end
         @(posedge clk); #1;
         lat++;
      end
      n_cmp++;
      if (lat != settle[u]) begin
         n_bad++; $display("FAIL latency u%0d: got %0d want %0d", u, lat, settle[u]);
      end
      n_cmp++;
      if (rsp_result[u] !== exp_res[u] || rsp_zero[u] !== exp_zero[u] || rsp_illegal[u] !== exp_ill[u]
          || req_ready[u] !== 1'b0) begin
         n_bad++; $display("FAIL response u%0d: got %h z%b i%b r%b want %h z%b i%b r0", u,
                           rsp_result[u], rsp_zero[u], rsp_illegal[u], req_ready[u],
                           exp_res[u], exp_zero[u], exp_ill[u]);
      end
   endtask

   // Hold the response for some cycles (optionally with a competing request) then hand it off.
   task automatic finish(input int u, input int hold, input bit hold_req);
      for (int i = 0; i < hold; i++) begin
         if (hold_req) begin
            req_valid[u] = 1'b1; req_a[u] = ~exp_a[u]; req_b[u] = ~exp_b[u]; req_op[u] = 4'd1;
         end
         @(posedge clk); #1;
         n_cmp++;
         if (rsp_valid[u] !== 1'b1 || req_ready[u] !== 1'b0 || rsp_result[u] !== exp_res[u]
             || rsp_zero[u] !== exp_zero[u] || alu_a[u] !== exp_a[u]) begin
            n_bad++; $display("FAIL backpressure u%0d: valid %b ready %b res %h want res %h alu_a %h want %h",
                              u, rsp_valid[u], req_ready[u], rsp_result[u], exp_res[u], alu_a[u], exp_a[u]);
         end
      end
      rsp_ready[u] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[u] = 1'b0;
      exp_cnt[u] = (exp_cnt[u] + 1) % cnt_mod(u);
      n_cmp++;
      if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1 || busy[u] !== 1'b0
          || cnt_of(u) !== 16'(exp_cnt[u]) || alu_a[u] !== exp_a[u] || alu_ctrl[u] !== exp_op[u]) begin
         n_bad++; $display("FAIL handoff u%0d: valid %b ready %b busy %b cnt %0d want %0d alu_a %h want %h",
                           u, rsp_valid[u], req_ready[u], busy[u], cnt_of(u), exp_cnt[u], alu_a[u], exp_a[u]);
      end
      req_valid[u] = 1'b0;
   endtask

   task automatic check_reset_vals(input int u, input string tag);
      n_cmp++;
      if (rsp_valid[u] !== 1'b0 || busy[u] !== 1'b0 || req_ready[u] !== 1'b1 || cnt_of(u) !== 16'd0
          || alu_a[u] !== 32'd0 || alu_b[u] !== 32'd0 || alu_ctrl[u] !== 4'd0 || rsp_result[u] !== 32'd0
          || rsp_zero[u] !== 1'b0 || rsp_illegal[u] !== 1'b0) begin
         n_bad++; $display("FAIL %s u%0d: valid %b busy %b ready %b cnt %0d alu %h/%h/%h rsp %h z%b i%b want reset values",
                           tag, u, rsp_valid[u], busy[u], req_ready[u], cnt_of(u), alu_a[u], alu_b[u],
                           alu_ctrl[u], rsp_result[u], rsp_zero[u], rsp_illegal[u]);
      end
   endtask

   task automatic pulse_reset(input int u, input string tag);
      reset[u] = 1'b1;
      #1;
      check_reset_vals(u, tag);
      @(negedge clk);
      reset[u] = 1'b0;
      exp_cnt[u] = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      for (int u = 0; u < 2; u++) begin
         req_valid[u] = 1'b0; rsp_ready[u] = 1'b0; req_op[u] = 4'd0; req_a[u] = '0; req_b[u] = '0;
         reset[u] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) check_reset_vals(u, "reset_state");
      @(negedge clk);
      reset[0] = 1'b0; reset[1] = 1'b0;
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      issue(0, 4'b0010, 32'h0000_0005, 32'h0000_0003);
      n_cmp++;
      if (rsp_result[0] !== 32'h8) begin
         n_bad++; $display("FAIL add_const: got %h want 00000008", rsp_result[0]);
      end
      finish(0, 0, 1'b0);
      n_cmp++;
      if (op_count0 !== 16'd1) begin
         n_bad++; $display("FAIL add_count: got %0d want 1", op_count0);
      end
   endtask

   task automatic test_sub();
      issue(0, 4'b0110, 32'h1234_5678, 32'h1234_5678);
      n_cmp++;
      if (rsp_result[0] !== 32'h0 || rsp_zero[0] !== 1'b1) begin
         n_bad++; $display("FAIL sub_equal: got %h z%b want 00000000 z1", rsp_result[0], rsp_zero[0]);
      end
      finish(0, 1, 1'b0);
      issue(0, 4'b0110, 32'd1, 32'd2);
      n_cmp++;
      if (rsp_result[0] !== 32'hFFFF_FFFF || rsp_zero[0] !== 1'b0) begin
         n_bad++; $display("FAIL sub_neg: got %h z%b want ffffffff z0", rsp_result[0], rsp_zero[0]);
      end
      finish(0, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      issue(0, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      n_cmp++;
      if (rsp_result[0] !== 32'hF000_F000) begin
         n_bad++; $display("FAIL and_const: got %h want f000f000", rsp_result[0]);
      end
      finish(0, 5, 1'b1);
   endtask

   task automatic test_illegal();
      issue(0, 4'b1111, 32'd7, 32'd9);
      n_cmp++;
      if (rsp_result[0] !== 32'd0 || rsp_zero[0] !== 1'b0 || rsp_illegal[0] !== 1'b1) begin
         n_bad++; $display("FAIL illegal: got %h z%b i%b want 00000000 z0 i1",
                           rsp_result[0], rsp_zero[0], rsp_illegal[0]);
      end
      finish(0, 2, 1'b0);
   endtask

   task automatic test_settle4();
      issue(1, 4'b0001, 32'h1, 32'h2);
      n_cmp++;
      if (rsp_result[1] !== 32'h3) begin
         n_bad++; $display("FAIL or_const: got %h want 00000003", rsp_result[1]);
      end
      finish(1, 1, 1'b0);
   endtask

   task automatic test_reset_mid();
      req_valid[1] = 1'b1; req_op[1] = 4'd2; req_a[1] = 32'd10; req_b[1] = 32'd20;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (busy[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
         n_bad++; $display("FAIL mid_wait_setup: busy %b valid %b want busy 1 valid 0", busy[1], rsp_valid[1]);
      end
      pulse_reset(1, "reset_in_wait");
      issue(1, 4'b0010, 32'd40, 32'd2);
      finish(1, 0, 1'b0);
      issue(1, 4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F);
      pulse_reset(1, "reset_in_resp");
      rsp_ready[1] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[1] = 1'b0;
      n_cmp++;
      if (op_count1 !== 2'd0 || rsp_valid[1] !== 1'b0) begin
         n_bad++; $display("FAIL discard_after_reset: cnt %0d valid %b want 0 0", op_count1, rsp_valid[1]);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 5; i++) begin
         issue(1, 4'b0010, $urandom, $urandom);
         finish(1, i % 2, 1'b0);
      end
      n_cmp++;
      if (op_count1 !== 2'd1) begin
         n_bad++; $display("FAIL wrap: got %0d want 1", op_count1);
      end
   endtask

   task automatic test_random();
      logic [3:0] ops [5];
      ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd0};
      for (int i = 0; i < 40; i++) begin
         int u;
         logic [3:0] op;
         logic [31:0] a, b;
         u  = i % 2;
         op = ops[$urandom_range(0, 3)];
         if ($urandom_range(0, 5) == 0) op = 4'($urandom);
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         issue(u, op, a, b);
         finish(u, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_illegal();
      test_settle4();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
